seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles per digit slot; legal range 2..65535.
REQ-002 Parameter COMMON_ANODE, default 0: 0 = active-high seg/digit_en outputs, 1 = active-low (both buses inverted).
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load  input  1  capture strobe for the digit inputs.
REQ-006 hundreds  input  4  BCD hundreds digit.
REQ-007 tens  input  4  BCD tens digit.
REQ-008 ones  input  4  BCD ones digit.
REQ-009 blank  input  1  forces all digits dark while high.
REQ-010 seg  output  7  segments; seg[0]=a ... seg[6]=g.
REQ-011 digit_en  output  3  digit select; [0]=ones, [1]=tens, [2]=hundreds.

Function
REQ-012 Three 4-bit digit registers SHALL load hundreds/tens/ones on every edge where load=1; otherwise hold.
REQ-013 A prescaler cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; a slot index idx SHALL advance 0->1->2->0 on the edge where cnt wraps.
REQ-014 seg and digit_en SHALL be registered; the value driven in cycle t+1 SHALL be a function of cnt, idx, digit registers and blank in cycle t (one-cycle output latency).
REQ-015 Active-level polarity (COMMON_ANODE=0): digit_en SHALL be one-hot with bit idx set; seg SHALL encode the digit register selected by idx.
REQ-016 Dead time: when cnt=SCAN_DIV-1, the next digit_en SHALL be all-off and seg all-off.
REQ-017 Decode (g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-018 Digit codes 10..15 SHALL display a dash (g only, 1000000), including in the hundreds and tens positions.
REQ-019 Leading-zero blanking: hundreds slot dark (digit_en and seg off) when hundreds register=0; tens slot dark when hundreds=0 and tens=0; ones slot never blanked.
REQ-020 A dark slot SHALL still consume SCAN_DIV cycles; scan timing SHALL NOT depend on displayed data.
REQ-021 blank=1 SHALL force the next digit_en and seg all-off; cnt, idx and digit registers SHALL keep running and loading unaffected.
REQ-022 load coincident with any scan event SHALL take effect for the display computed from the following cycle; no partial-digit update within one output cycle.
REQ-023 COMMON_ANODE=1 SHALL invert every bit of seg and digit_en, including reset and dark values.

Reset
REQ-024 While rst=1: digit registers=0, cnt=0, idx=0, seg and digit_en at off-level (0 for COMMON_ANODE=0, all-ones for 1); load is ignored.
REQ-025 rst SHALL take priority over load and blank; assertion mid-slot SHALL abort the slot at the next edge.
REQ-026 First edge after rst deasserts SHALL compute outputs from cnt=0, idx=0 (ones slot, displaying 0 -> 0111111).

Verification (SCAN_DIV=4, COMMON_ANODE=0 unless stated)
REQ-027 Load 1/2/3, run 12 cycles -> ones slot shows 1001111 with digit_en=001 for 3 cycles, 1 dead cycle, then tens 1011011/010, then hundreds 0000110/100, repeating every 12 cycles.
REQ-028 Load 0/0/7 -> only digit_en=001 ever asserted, seg=0000111; tens and hundreds slots dark for their full 4 cycles.
REQ-029 Load 0/5/0 -> tens slot shows 1101101, ones 0111111, hundreds dark; load 12/0/0 -> hundreds slot shows dash 1000000, tens 0111111.
REQ-030 blank=1 for 6 cycles mid-scan -> outputs all-off from next cycle; after release, slot sequence resumes at the position dictated by uninterrupted cnt/idx.
REQ-031 rst pulsed during hundreds slot -> next cycle outputs off, digit registers cleared; after release ones slot with 0111111 first.
REQ-032 COMMON_ANODE=1 repeat of REQ-027 -> every seg/digit_en value bitwise inverted; reset and dead cycles drive seg=1111111, digit_en=111.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Three-digit multiplexed seven-segment driver: captures BCD digits, scans one digit
// slot per SCAN_DIV cycles with a dead cycle, leading-zero blanking and registered outputs.
module seven_seg_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [2:0] digit_en
);

  localparam logic [15:0] LAST_CNT = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_OFF  = {7{COMMON_ANODE}};
  localparam logic [2:0]  EN_OFF   = {3{COMMON_ANODE}};

  // Index 0 = ones, 1 = tens, 2 = hundreds, matching the digit_en bit order.
  logic [2:0][3:0] digit_reg;
  logic [15:0]     cnt_reg;
  logic [1:0]      idx_reg;

  logic [3:0] cur_digit;
  logic       slot_lit;
  logic       active;
  logic [2:0] en_active;
  logic [6:0] seg_next;
  logic [2:0] digit_en_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction

  always_comb begin
    cur_digit = 4'd0;
    slot_lit  = 1'b0;
    case (idx_reg)
      2'd0: begin
        cur_digit = digit_reg[0];
        slot_lit  = 1'b1;
      end
      2'd1: begin
        cur_digit = digit_reg[1];
        slot_lit  = (digit_reg[2] != 4'd0) || (digit_reg[1] != 4'd0);
      end
      2'd2: begin
        cur_digit = digit_reg[2];
        slot_lit  = (digit_reg[2] != 4'd0);
      end
      default: begin
        cur_digit = 4'd0;
        slot_lit  = 1'b0;
      end
    endcase
    // The final count of each slot is a dead cycle to avoid ghosting between digits.
    active   = slot_lit && !blank && (cnt_reg != LAST_CNT);
    seg_next = active ? (decode(cur_digit) ^ SEG_OFF) : SEG_OFF;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_en
    assign en_active[gi] = active && (idx_reg == 2'(gi));
  end

  assign digit_en_next = en_active ^ EN_OFF;

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_reg <= '0;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      seg       <= SEG_OFF;
      digit_en  <= EN_OFF;
    end else begin
      if (load) begin
        digit_reg <= {hundreds, tens, ones};
      end
      if (cnt_reg == LAST_CNT) begin
        cnt_reg <= '0;
        idx_reg <= (idx_reg == 2'd2) ? 2'd0 : idx_reg + 2'd1;
      end else begin
        cnt_reg <= cnt_reg + 16'd1;
      end
      seg      <= seg_next;
      digit_en <= digit_en_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner: two instances (common cathode and common anode)
// checked every cycle against a time-since-reset reference model plus literal sequences.
module tb_seven_seg_scanner;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] hundreds = 4'd0;
  logic [3:0] tens = 4'd0;
  logic [3:0] ones = 4'd0;
  logic       blank = 1'b0;
  logic [6:0] seg_a, seg_b;
  logic [2:0] en_a, en_b;

  int n_checks = 0;
  int n_errors = 0;

  seven_seg_scanner #(.SCAN_DIV(DIV), .COMMON_ANODE(1'b0)) dut_cc (
    .clk(clk), .rst(rst), .load(load), .hundreds(hundreds), .tens(tens), .ones(ones),
    .blank(blank), .seg(seg_a), .digit_en(en_a)
  );

  seven_seg_scanner #(.SCAN_DIV(DIV), .COMMON_ANODE(1'b1)) dut_ca (
    .clk(clk), .rst(rst), .load(load), .hundreds(hundreds), .tens(tens), .ones(ones),
    .blank(blank), .seg(seg_b), .digit_en(en_b)
  );

  always #5 clk = ~clk;

  // Reference model: slot position derived purely from cycles elapsed since reset.
  logic [6:0] seg_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
                               7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
  int         m_t = 0;
  logic [3:0] m_dig [3] = '{4'd0, 4'd0, 4'd0};
  logic [6:0] exp_seg = 7'd0;
  logic [2:0] exp_en = 3'd0;

  function automatic logic [2:0] model_en(int t);
    int pos, slot;
    pos  = t % DIV;
    slot = (t / DIV) % 3;
    if (blank || pos == DIV - 1) return 3'b000;
    if (slot == 2 && m_dig[2] == 4'd0) return 3'b000;
    if (slot == 1 && m_dig[2] == 4'd0 && m_dig[1] == 4'd0) return 3'b000;
    return 3'(1 << slot);
  endfunction

  function automatic logic [6:0] model_seg(int t);
    if (model_en(t) == 3'b000) return 7'd0;
    return seg_tab[m_dig[(t / DIV) % 3]];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_t      <= 0;
      m_dig[0] <= 4'd0;
      m_dig[1] <= 4'd0;
      m_dig[2] <= 4'd0;
      exp_seg  <= 7'd0;
      exp_en   <= 3'd0;
    end else begin
      exp_seg <= model_seg(m_t);
      exp_en  <= model_en(m_t);
      m_t     <= m_t + 1;
      if (load) begin
        m_dig[0] <= ones;
        m_dig[1] <= tens;
        m_dig[2] <= hundreds;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; blank = 1'b0;
    hundreds = 4'($urandom_range(1, 9)); tens = 4'($urandom_range(1, 9)); ones = 4'($urandom_range(1, 9));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({seg_a, en_a, seg_b, en_b} !== {7'b0, 3'b0, 7'h7f, 3'b111}) begin
        n_errors++;
        $display("FAIL reset_off cyc=%0d got %b/%b inv %b/%b want 0000000/000 inv 1111111/111",
                 i, seg_a, en_a, seg_b, en_b);
      end
    end
    rst = 1'b0; hundreds = 4'd1; tens = 4'd2; ones = 4'd3;
    @(negedge clk);
    n_checks++;
    if ({seg_a, en_a, seg_b, en_b} !== {7'b0111111, 3'b001, 7'b1000000, 3'b110}) begin
      n_errors++;
      $display("FAIL first_after_reset got %b/%b inv %b/%b want 0111111/001 inv 1000000/110",
               seg_a, en_a, seg_b, en_b);
    end
    load = 1'b0;
    for (int i = 1; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if ({seg_a, en_a, seg_b, en_b} !== {exp_seg, exp_en, ~exp_seg, ~exp_en}) begin
        n_errors++;
        $display("FAIL reset_run cyc=%0d got %b/%b inv %b/%b want %b/%b", i, seg_a, en_a, seg_b, en_b, exp_seg, exp_en);
      end
    end
    // A full period of 1/2/3 checked against the literal scan sequence.
    for (int k = 0; k < 12; k++) begin
      logic [6:0] ls;
      logic [2:0] le;
      if (k % 4 == 3) begin ls = 7'b0000000; le = 3'b000; end
      else if (k < 4) begin ls = 7'b1001111; le = 3'b001; end
      else if (k < 8) begin ls = 7'b1011011; le = 3'b010; end
      else begin ls = 7'b0000110; le = 3'b100; end
      @(negedge clk);
      n_checks++;
      if ({seg_a, en_a, seg_b, en_b} !== {ls, le, ~ls, ~le}) begin
        n_errors++;
        $display("FAIL seq_123 k=%0d got %b/%b inv %b/%b want %b/%b", k, seg_a, en_a, seg_b, en_b, ls, le);
      end
    end
    $display("test_reset: reset, first edge and 1/2/3 scan period done");
  endtask

  task automatic test_leading_zero();
    hundreds = 4'd0; tens = 4'd0; ones = 4'd7; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      n_checks++;
      if ({seg_a, en_a, seg_b, en_b} !== {exp_seg, exp_en, ~exp_seg, ~exp_en}) begin
        n_errors++;
        $display("FAIL lz_model cyc=%0d got %b/%b want %b/%b", i, seg_a, en_a, exp_seg, exp_en);
      end
      if (i > 0) begin
        n_checks++;
        if (!(en_a === 3'b000 && seg_a === 7'b0) && !(en_a === 3'b001 && seg_a === 7'b0000111)) begin
          n_errors++;
          $display("FAIL lz_007 cyc=%0d got %b/%b want 0000111/001 or dark", i, seg_a, en_a);
        end
      end
    end
    $display("test_leading_zero: 0/0/7 for 24 cycles");
  endtask

  task automatic test_patterns();
    logic [3:0] ph [2] = '{4'd0, 4'd12};
    logic [3:0] pt [2] = '{4'd5, 4'd0};
    logic [6:0] want_seg;
    logic [2:0] want_en;
    for (int p = 0; p < 2; p++) begin
      hundreds = ph[p]; tens = pt[p]; ones = 4'd0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      want_en  = (p == 0) ? 3'b010 : 3'b100;
      want_seg = (p == 0) ? 7'b1101101 : 7'b1000000;
      for (int i = 0; i < 13; i++) begin
        @(negedge clk);
        n_checks++;
        if ({seg_a, en_a, seg_b, en_b} !== {exp_seg, exp_en, ~exp_seg, ~exp_en}) begin
          n_errors++;
          $display("FAIL pat_model p=%0d cyc=%0d got %b/%b want %b/%b", p, i, seg_a, en_a, exp_seg, exp_en);
        end
        if (i > 0 && en_a === want_en) begin
          n_checks++;
          if (seg_a !== want_seg) begin
            n_errors++;
            $display("FAIL pat_digit p=%0d cyc=%0d got seg=%b want %b", p, i, seg_a, want_seg);
          end
        end
      end
      $display("test_patterns: loaded %0d/%0d/0", ph[p], pt[p]);
    end
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      n_checks++;
      if ({seg_a, en_a, seg_b, en_b} !== {exp_seg, exp_en, ~exp_seg, ~exp_en}) begin
        n_errors++;
        $display("FAIL rand_model cyc=%0d got %b/%b inv %b/%b want %b/%b", i, seg_a, en_a, seg_b, en_b, exp_seg, exp_en);
      end
      load = ($urandom_range(0, 7) == 0);
      hundreds = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      tens     = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      ones     = 4'($urandom_range(0, 15));
    end
    load = 1'b0;
    $display("test_patterns: 150 random-load cycles");
  endtask

  task automatic test_blank();
    hundreds = 4'd8; tens = 4'd4; ones = 4'd9; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat ($urandom_range(2, 9)) @(negedge clk);
    blank = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 5) blank = 1'b0;
      n_checks++;
      if ({seg_a, en_a, seg_b, en_b} !== {exp_seg, exp_en, ~exp_seg, ~exp_en}) begin
        n_errors++;
        $display("FAIL blank_model cyc=%0d got %b/%b want %b/%b", i, seg_a, en_a, exp_seg, exp_en);
      end
      if (i < 6) begin
        n_checks++;
        if ({seg_a, en_a, seg_b, en_b} !== {7'b0, 3'b0, 7'h7f, 3'b111}) begin
          n_errors++;
          $display("FAIL blank_off cyc=%0d got %b/%b inv %b/%b want all off", i, seg_a, en_a, seg_b, en_b);
        end
      end
    end
    $display("test_blank: 6-cycle blank window and resume");
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    hundreds = 4'd6; tens = 4'd6; ones = 4'd6; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (((m_t / DIV) % 3) == 2 && (m_t % DIV) == 1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL reset_mid_wait got no hundreds slot within 20 cycles want one");
    end
    rst = 1'b1; load = 1'b1; hundreds = 4'd9;
    @(negedge clk);
    n_checks++;
    if ({seg_a, en_a, seg_b, en_b} !== {7'b0, 3'b0, 7'h7f, 3'b111}) begin
      n_errors++;
      $display("FAIL reset_mid_off got %b/%b inv %b/%b want all off", seg_a, en_a, seg_b, en_b);
    end
    rst = 1'b0; load = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({seg_a, en_a} !== {7'b0111111, 3'b001}) begin
      n_errors++;
      $display("FAIL reset_mid_first got %b/%b want 0111111/001", seg_a, en_a);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if ({seg_a, en_a, seg_b, en_b} !== {exp_seg, exp_en, ~exp_seg, ~exp_en}) begin
        n_errors++;
        $display("FAIL reset_mid_model cyc=%0d got %b/%b want %b/%b", i, seg_a, en_a, exp_seg, exp_en);
      end
    end
    $display("test_reset_mid: reset pulsed in hundreds slot");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      n_checks++;
      if ({seg_a, en_a, seg_b, en_b} !== {exp_seg, exp_en, ~exp_seg, ~exp_en}) begin
        n_errors++;
        $display("FAIL b2b_model cyc=%0d got %b/%b inv %b/%b want %b/%b", i, seg_a, en_a, seg_b, en_b, exp_seg, exp_en);
      end
      load     = 1'b1;
      blank    = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 49) == 0);
      hundreds = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      tens     = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      ones     = 4'($urandom_range(0, 15));
    end
    load = 1'b0; blank = 1'b0; rst = 1'b0;
    $display("test_back_to_back: 250 cycles of continuous loads");
  endtask

  initial begin
    test_reset();
    test_leading_zero();
    test_patterns();
    test_blank();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
